// File: rtl/fd_pipe_reg_pkg.sv
// Shared IF/ID definitions: opcodes, funct codes, exception codes, reset PC.
// Reused by decode and CP0.
package fd_pipe_reg_pkg;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;

   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;

   localparam logic [4:0] EXC_NONE   = 5'd0;
   localparam logic [4:0] EXC_ADEL   = 5'd4;

   localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
      logic [31:0] pc;
      logic        valid;
      logic [4:0]  exc;
      logic        bd;
   } if_id_t;

endpackage

// File: rtl/fd_pipe_reg_br_predecode.sv
// Combinational branch/jump predecode: flags any instruction
// that owns a delay slot.
module br_predecode
   import fd_pipe_reg_pkg::*;
(
   input  logic [31:0] instr_i,
   output logic        is_branch_o
);

   logic [5:0] op;
   logic [5:0] fn;
   logic       unused_bits;

   assign op = instr_i[31:26];
   assign fn = instr_i[5:0];
   assign unused_bits = ^instr_i[25:6];

   always_comb begin
      is_branch_o = 1'b0;
      unique case (op)
         OP_REGIMM, OP_J, OP_JAL,
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
            is_branch_o = 1'b1;
         OP_SPECIAL:
            is_branch_o = (fn == FN_JR) || (fn == FN_JALR);
         default:
            is_branch_o = 1'b0;
      endcase
   end

endmodule

// File: rtl/fd_pipe_reg.sv
// IF/ID pipeline register with stall, flush/interrupt bubbles and BD tracking.
// Define FD_PERF_CNT_EN to add the saturating STALL_CNT output.
module fd_pipe_reg
   import fd_pipe_reg_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        STALL_D,
   input  logic        FLUSH_D,
   input  logic        INT_REQ,
   input  logic [31:0] INSTR_F,
   input  logic [31:0] PCadd4F,
   input  logic [31:0] PC,
   input  logic        PC_EXP,
   output logic [31:0] INSTR_D,
   output logic [31:0] PCadd4D,
   output logic [31:0] PC_D,
   output logic        VALID_D,
   output logic [4:0]  EXC_D,
   output logic        BD_D
`ifdef FD_PERF_CNT_EN
   ,
   output logic [31:0] STALL_CNT
`endif
);

   localparam if_id_t RST_VAL = '{
      instr: 32'h0,
      pc4:   RESET_PC + 32'd4,
      pc:    RESET_PC,
      valid: 1'b0,
      exc:   EXC_NONE,
      bd:    1'b0
   };

   if_id_t r_q, r_d;
   logic   d_is_br;
   logic   bubble;

   br_predecode u_predec (
      .instr_i     (r_q.instr),
      .is_branch_o (d_is_br)
   );

   assign bubble = FLUSH_D | INT_REQ;

   always_comb begin
      r_d = r_q;
      if (bubble) begin
         // Bubble still carries the victim PC for EPC.
         r_d.instr = 32'h0;
         r_d.pc4   = PCadd4F;
         r_d.pc    = PC;
         r_d.valid = 1'b0;
         r_d.exc   = EXC_NONE;
         r_d.bd    = 1'b0;
      end else if (!STALL_D) begin
         r_d.pc4   = PCadd4F;
         r_d.pc    = PC;
         r_d.valid = 1'b1;
         r_d.bd    = r_q.valid & d_is_br;
         r_d.instr = PC_EXP ? 32'h0 : INSTR_F;
         r_d.exc   = PC_EXP ? EXC_ADEL : EXC_NONE;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) r_q <= RST_VAL;
      else       r_q <= r_d;
   end

   assign INSTR_D = r_q.instr;
   assign PCadd4D = r_q.pc4;
   assign PC_D    = r_q.pc;
   assign VALID_D = r_q.valid;
   assign EXC_D   = r_q.exc;
   assign BD_D    = r_q.bd;

`ifdef FD_PERF_CNT_EN
   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (STALL_D && !bubble && (cnt_q != 32'hFFFF_FFFF))
         cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk) begin
      if (reset) cnt_q <= 32'h0;
      else       cnt_q <= cnt_d;
   end

   assign STALL_CNT = cnt_q;
`endif

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Random + directed bench for fd_pipe_reg against a behavioural model.
// Define FD_PERF_CNT_EN to also check STALL_CNT.
module tb_fd_pipe_reg;

   logic        clk = 1'b0;
   logic        reset, STALL_D, FLUSH_D, INT_REQ, PC_EXP;
   logic [31:0] INSTR_F, PCadd4F, PC;
   logic [31:0] INSTR_D, PCadd4D, PC_D;
   logic        VALID_D, BD_D;
   logic [4:0]  EXC_D;
`ifdef FD_PERF_CNT_EN
   logic [31:0] STALL_CNT;
`endif

   int checks = 0;
   int errors = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   fd_pipe_reg dut (
      .clk(clk), .reset(reset), .STALL_D(STALL_D),
      .FLUSH_D(FLUSH_D), .INT_REQ(INT_REQ),
      .INSTR_F(INSTR_F), .PCadd4F(PCadd4F), .PC(PC),
      .PC_EXP(PC_EXP), .INSTR_D(INSTR_D), .PCadd4D(PCadd4D),
      .PC_D(PC_D), .VALID_D(VALID_D), .EXC_D(EXC_D), .BD_D(BD_D)
`ifdef FD_PERF_CNT_EN
      , .STALL_CNT(STALL_CNT)
`endif
   );

   // model state
   logic [31:0] m_instr, m_pc4, m_pc, m_cnt;
   logic        m_valid, m_bd;
   logic [4:0]  m_exc;

   function automatic logic has_slot(input logic [31:0] i);
      int op, fn;
      op = int'(i[31:26]);
      fn = int'(i[5:0]);
      if (op >= 1 && op <= 7) return 1'b1;
      if (op == 0 && (fn == 8 || fn == 9)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      if (reset) begin
         m_instr = 0; m_pc = 32'h3000; m_pc4 = 32'h3004;
         m_valid = 0; m_exc = 0; m_bd = 0; m_cnt = 0;
      end else if (FLUSH_D || INT_REQ) begin
         m_instr = 0; m_pc = PC; m_pc4 = PCadd4F;
         m_valid = 0; m_exc = 0; m_bd = 0;
      end else if (STALL_D) begin
         if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else begin
         m_bd    = m_valid && has_slot(m_instr);
         m_pc    = PC;
         m_pc4   = PCadd4F;
         m_valid = 1;
         m_instr = PC_EXP ? 32'h0 : INSTR_F;
         m_exc   = PC_EXP ? 5'd4 : 5'd0;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("INSTR_D", INSTR_D, m_instr);
         chk("PCadd4D", PCadd4D, m_pc4);
         chk("PC_D", PC_D, m_pc);
         chk("VALID_D", {31'b0, VALID_D}, {31'b0, m_valid});
         chk("EXC_D", {27'b0, EXC_D}, {27'b0, m_exc});
         chk("BD_D", {31'b0, BD_D}, {31'b0, m_bd});
`ifdef FD_PERF_CNT_EN
         chk("STALL_CNT", STALL_CNT, m_cnt);
`endif
      end
   end

   task automatic drive(input logic st, input logic fl, input logic ir,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input logic exp);
      STALL_D = st; FLUSH_D = fl; INT_REQ = ir;
      INSTR_F = ins; PC = pc; PCadd4F = pc + 32'd4; PC_EXP = exp;
   endtask

   task automatic cyc();
      @(negedge clk);
      #1;
   endtask

   logic [31:0] pool [8] = '{32'h1000_0003, 32'h0C00_0C10, 32'h0000_0008,
                              32'h0000_0009, 32'h2008_0005, 32'h0000_0000,
                              32'h0411_0002, 32'h8C09_0004};

   initial begin
      reset = 1'b1;
      drive(0, 0, 0, 32'h0, 32'h0, 0);
      cyc(); cyc();
      chk("rst_INSTR", INSTR_D, 32'h0);
      chk("rst_PC", PC_D, 32'h3000);
      chk("rst_PC4", PCadd4D, 32'h3004);
      chk("rst_VALID", {31'b0, VALID_D}, 32'h0);
      chk_en = 1'b1;

      reset = 1'b0;
      drive(0, 0, 0, 32'h2008_0005, 32'h3000, 0);
      chk("pre_edge_INSTR", INSTR_D, 32'h0);
      cyc();
      chk("ld_INSTR", INSTR_D, 32'h2008_0005);
      chk("ld_PC", PC_D, 32'h3000);
      chk("ld_VALID", {31'b0, VALID_D}, 32'h1);
      chk("ld_BD", {31'b0, BD_D}, 32'h0);

      drive(0, 0, 0, 32'h1000_0003, 32'h3004, 0); cyc();
      drive(0, 0, 0, 32'h0000_0000, 32'h3008, 0); cyc();
      chk("slot_BD", {31'b0, BD_D}, 32'h1);
      chk("slot_PC", PC_D, 32'h3008);

      drive(0, 0, 0, 32'h1000_0003, 32'h300C, 0); cyc();
      for (int i = 0; i < 3; i++) begin
         drive(1, 0, 0, 32'hAAAA_0000 + i, 32'h4000 + i*4, 0); cyc();
         chk("stall_INSTR", INSTR_D, 32'h1000_0003);
         chk("stall_PC", PC_D, 32'h300C);
      end
`ifdef FD_PERF_CNT_EN
      chk("stall_cnt3", STALL_CNT, 32'd3);
`endif
      drive(0, 0, 0, 32'h2409_0001, 32'h3010, 0); cyc();
      chk("rel_INSTR", INSTR_D, 32'h2409_0001);
      chk("rel_BD", {31'b0, BD_D}, 32'h1);

      drive(0, 0, 0, 32'h1000_0003, 32'h3014, 0); cyc();
      drive(1, 1, 0, 32'h1234_5678, 32'h300C, 0); cyc();
      chk("fl_INSTR", INSTR_D, 32'h0);
      chk("fl_VALID", {31'b0, VALID_D}, 32'h0);
      chk("fl_BD", {31'b0, BD_D}, 32'h0);
      chk("fl_PC", PC_D, 32'h300C);

      drive(0, 0, 0, 32'h1000_0003, 32'h3002, 1); cyc();
      chk("exp_INSTR", INSTR_D, 32'h0);
      chk("exp_VALID", {31'b0, VALID_D}, 32'h1);
      chk("exp_EXC", {27'b0, EXC_D}, 32'd4);
      chk("exp_PC", PC_D, 32'h3002);
      drive(0, 0, 0, 32'h2008_0005, 32'h3018, 0); cyc();
      chk("exp_next_BD", {31'b0, BD_D}, 32'h0);

      drive(0, 0, 0, 32'h0C00_0C10, 32'h301C, 0); cyc();
      drive(0, 0, 1, 32'h2008_0005, 32'h3020, 0); cyc();
      chk("int_BD", {31'b0, BD_D}, 32'h0);
      chk("int_PC", PC_D, 32'h3020);
      chk("int_VALID", {31'b0, VALID_D}, 32'h0);

      drive(0, 0, 0, 32'h0C00_0C10, 32'h3024, 0); cyc();
      drive(1, 0, 1, 32'h2008_0005, 32'h3028, 0);
      reset = 1'b1; cyc();
      reset = 1'b0;
      chk("rst2_PC", PC_D, 32'h3000);
      chk("rst2_INSTR", INSTR_D, 32'h0);
      chk("rst2_VALID", {31'b0, VALID_D}, 32'h0);

      for (int n = 0; n < 3000; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         drive($urandom_range(0, 3) == 0,
               $urandom_range(0, 11) == 0,
               $urandom_range(0, 15) == 0,
               pool[$urandom_range(0, 7)],
               32'h3000 + ($urandom_range(0, 255) << 2),
               $urandom_range(0, 9) == 0);
         cyc();
      end

      chk_en = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
